// File: rtl/freq_counter_axi_slave_if.sv
// AXI4-Lite bus bundle for the frequency counter peripheral.
// The slave modport is used by the counter; master is used by whoever drives it.
interface freq_counter_axi_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/freq_counter_axi_slave.sv
// Frequency counter: counts rising edges of freq_in over a GATE-cycle window,
// with CTRL/GATE/COUNT/STATUS registers behind an AXI4-Lite slave.
//
// state      | meaning
// ST_IDLE    | no measurement running, waiting for CTRL.start
// ST_MEASURE | gate window open, edges counted, gate_cnt counting down
// ST_DONE    | one-cycle gap after a window; restart if continuous
module freq_counter_axi_slave #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] GATE_DEFAULT       = 32'd50000000,
    parameter int          COUNT_WIDTH        = 32
) (
    input  logic                     S_AXI_ACLK,
    input  logic                     S_AXI_ARESETN,
    freq_counter_axi_slave_if.slave  s_axi,
    input  logic                     freq_in,
    output logic                     irq
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            gate_q, gate_d;
    logic [31:0]            gate_cnt_q, gate_cnt_d;
    logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;
    logic                   missed_q, missed_d;
    logic                   cont_q, cont_d;
    logic                   irq_en_q, irq_en_d;
    logic                   awready_q, awready_d;
    logic                   bvalid_q, bvalid_d;
    logic                   arready_q, arready_d;
    logic                   rvalid_q, rvalid_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [2:0]             sync_q, sync_d;

    logic                   wr_hs, rd_hs;
    logic [1:0]             wr_idx, rd_idx;
    logic                   ctrl_wr, start_req, abort_req;
    logic                   edge_det, busy;
    logic [31:0]            gate_load;
    logic [COUNT_WIDTH-1:0] edge_next;
    logic                   unused_bits;

    assign wr_hs     = awready_q & s_axi.awvalid & s_axi.wvalid;
    assign rd_hs     = arready_q & s_axi.arvalid;
    assign wr_idx    = s_axi.awaddr[3:2];
    assign rd_idx    = s_axi.araddr[3:2];
    assign ctrl_wr   = wr_hs & (wr_idx == 2'd0) & s_axi.wstrb[0];
    assign start_req = ctrl_wr & s_axi.wdata[0];
    assign abort_req = ctrl_wr & s_axi.wdata[3];
    assign edge_det  = sync_q[1] & ~sync_q[2];
    assign busy      = (state_q == ST_MEASURE);
    // A zero GATE behaves as a one-cycle window.
    assign gate_load = (gate_q == 32'd0) ? 32'd0 : gate_q - 32'd1;
    assign edge_next = (edge_det && edge_cnt_q != '1) ? edge_cnt_q + COUNT_WIDTH'(1) : edge_cnt_q;

    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr, s_axi.araddr};

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        count_d    = count_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        missed_d   = missed_q;
        cont_d     = cont_q;
        irq_en_d   = irq_en_q;
        bvalid_d   = bvalid_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        sync_d     = {sync_q[1:0], freq_in};
        awready_d  = s_axi.awvalid & s_axi.wvalid & ~bvalid_q & ~awready_q;
        arready_d  = s_axi.arvalid & ~rvalid_q & ~arready_q;

        if (bvalid_q && s_axi.bready) bvalid_d = 1'b0;
        if (wr_hs)                    bvalid_d = 1'b1;
        if (rvalid_q && s_axi.rready) rvalid_d = 1'b0;

        if (rd_hs) begin
            rvalid_d = 1'b1;
            case (rd_idx)
                2'd0: rdata_d = {28'd0, 1'b0, irq_en_q, cont_q, 1'b0};
                2'd1: rdata_d = gate_q;
                2'd2: rdata_d = 32'(count_q);
                2'd3: rdata_d = {28'd0, missed_q, ovf_q, busy, valid_q};
            endcase
        end

        if (wr_hs) begin
            case (wr_idx)
                2'd0: if (s_axi.wstrb[0]) begin
                    cont_d   = s_axi.wdata[1];
                    irq_en_d = s_axi.wdata[2];
                end
                2'd1: for (int b = 0; b < 4; b++) begin
                    if (s_axi.wstrb[b]) gate_d[8*b +: 8] = s_axi.wdata[8*b +: 8];
                end
                2'd3: if (s_axi.wstrb[0]) begin
                    if (s_axi.wdata[2]) ovf_d    = 1'b0;
                    if (s_axi.wdata[3]) missed_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (rd_hs && rd_idx == 2'd2) valid_d = 1'b0;

        // Window-completion sets below override the read-clear and W1C above.
        if (abort_req) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_req) begin
                    state_d    = ST_MEASURE;
                    gate_cnt_d = gate_load;
                    edge_cnt_d = '0;
                end
                ST_MEASURE: begin
                    edge_cnt_d = edge_next;
                    if (edge_det && edge_cnt_q == '1) ovf_d = 1'b1;
                    if (gate_cnt_q == 32'd0) begin
                        count_d = edge_next;
                        valid_d = 1'b1;
                        if (valid_q) missed_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        gate_cnt_d = gate_cnt_q - 32'd1;
                    end
                end
                ST_DONE: begin
                    if (cont_q) begin
                        state_d    = ST_MEASURE;
                        gate_cnt_d = gate_load;
                        edge_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q    <= ST_IDLE;
            gate_q     <= GATE_DEFAULT;
            gate_cnt_q <= 32'd0;
            edge_cnt_q <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            missed_q   <= 1'b0;
            cont_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'd0;
            sync_q     <= 3'd0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            missed_q   <= missed_d;
            cont_q     <= cont_d;
            irq_en_q   <= irq_en_d;
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            sync_q     <= sync_d;
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = awready_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;
    assign s_axi.rvalid  = rvalid_q;
    assign irq           = valid_q & irq_en_q;

endmodule

// File: tb/tb_freq_counter_axi_slave.sv
// Scoreboard bench for freq_counter_axi_slave: stimulus queues expected B/R
// responses, a negedge monitor pops and compares them at each handshake.
module tb_freq_counter_axi_slave;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] mask;
        string       name;
    } rexp_t;

    logic clk;
    logic rst_n;
    logic freq_in;
    logic irq;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   fin_half = 0;

    rexp_t       rq[$];
    logic [1:0]  bq[$];
    rexp_t       me;
    logic [1:0]  mb;
    logic [31:0] mval;

    freq_counter_axi_slave_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    freq_counter_axi_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .GATE_DEFAULT      (32'd50000000),
        .COUNT_WIDTH       (32)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .s_axi        (bus),
        .freq_in      (freq_in),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        int ph;
        ph = 0;
        freq_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (fin_half == 0) begin
                freq_in = 1'b0;
                ph = 0;
            end else begin
                ph = ph + 1;
                if (ph >= fin_half) begin
                    ph = 0;
                    freq_in = ~freq_in;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: one pop per completed handshake (handshake completes at the next posedge).
    always @(negedge clk) begin
        if (bus.bvalid && bus.bready) begin
            n_vec++;
            if (bq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_b: got bresp %0b required no response", bus.bresp);
            end else begin
                mb = bq.pop_front();
                if (bus.bresp !== mb) begin
                    n_err++;
                    $display("FAIL bresp: got %0b required %0b", bus.bresp, mb);
                end
            end
        end
        if (bus.rvalid && bus.rready) begin
            n_vec++;
            if (rq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_r: got 0x%08h required no response", bus.rdata);
            end else begin
                me   = rq.pop_front();
                mval = bus.rdata & me.mask;
                if (mval < me.lo || mval > me.hi || bus.rresp !== 2'b00) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h (masked 0x%08h, rresp %0b) required 0x%08h..0x%08h mask 0x%08h rresp 00",
                             me.name, bus.rdata, mval, bus.rresp, me.lo, me.hi, me.mask);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout required handshake", name);
    endtask

    task automatic aw_w_drive(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bq.push_back(2'b00);
        @(posedge clk);
        #1;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
    endtask

    task automatic aw_w_accept();
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.awready && bus.wready) begin ok = 1; break; end
        end
        if (!ok) timeout("aw_accept");
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    task automatic b_wait();
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.bvalid && bus.bready) begin ok = 1; break; end
        end
        if (!ok) timeout("b_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        aw_w_drive(addr, data, strb);
        aw_w_accept();
        b_wait();
    endtask

    task automatic ar_phase(input logic [3:0] addr, input logic [31:0] lo, input logic [31:0] hi,
                            input logic [31:0] mask, input string name);
        rexp_t e;
        bit    ok;
        e.lo = lo; e.hi = hi; e.mask = mask; e.name = name;
        rq.push_back(e);
        @(posedge clk);
        #1;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.arready) begin ok = 1; break; end
        end
        if (!ok) timeout("ar_accept");
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic r_wait();
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.rvalid && bus.rready) begin ok = 1; break; end
        end
        if (!ok) timeout("r_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
        ar_phase(addr, exp, exp, 32'hFFFF_FFFF, name);
        r_wait();
    endtask

    task automatic axi_read_rng(input logic [3:0] addr, input logic [31:0] lo, input logic [31:0] hi,
                                input logic [31:0] mask, input string name);
        ar_phase(addr, lo, hi, mask, name);
        r_wait();
    endtask

    task automatic wait_irq(output int t);
        bit ok;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (irq) begin ok = 1; break; end
        end
        if (!ok) timeout("irq_rise");
        t = cyc;
    endtask

    initial begin
        int t0, t1, t2;
        int stable, acc;
        logic [31:0] rd0;
        rst_n       = 1'b0;
        bus.awaddr  = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata   = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        bus.araddr  = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {25'd0, bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, irq, |bus.rdata},
              32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset register values
        axi_read(4'h0, 32'h0000_0000, "rst_ctrl");
        axi_read(4'h4, 32'd50000000,  "rst_gate");
        axi_read(4'h8, 32'h0000_0000, "rst_count");
        axi_read(4'hC, 32'h0000_0000, "rst_status");

        // 1000-cycle window, freq_in period 10 -> 100 edges
        fin_half = 5;
        axi_write(4'h4, 32'd1000, 4'hF);
        axi_read(4'h4, 32'd1000, "gate_1000");
        axi_write(4'h0, 32'h1, 4'hF);
        repeat (500) @(posedge clk);
        axi_read(4'hC, 32'h2, "status_busy");
        repeat (600) @(posedge clk);
        axi_read(4'hC, 32'h1, "status_valid");
        axi_read_rng(4'h8, 32'd99, 32'd101, 32'hFFFF_FFFF, "count_100");
        axi_read(4'hC, 32'h0, "status_cleared");

        // GATE=0 behaves as a 1-cycle window, freq_in toggling every clock
        fin_half = 1;
        axi_write(4'h4, 32'd0, 4'hF);
        axi_write(4'h0, 32'h1, 4'hF);
        repeat (20) @(posedge clk);
        axi_read(4'hC, 32'h1, "gate0_valid");
        axi_read_rng(4'h8, 32'd0, 32'd1, 32'hFFFF_FFFF, "gate0_count");
        axi_read(4'hC, 32'h0, "gate0_cleared");

        // Continuous mode with irq: period GATE+1 = 201 cycles, 50 edges per window
        fin_half = 2;
        axi_write(4'h4, 32'd200, 4'hF);
        axi_write(4'h0, 32'h7, 4'hF);
        axi_read(4'h0, 32'h6, "ctrl_cont_irq");
        wait_irq(t0);
        axi_read_rng(4'h8, 32'd49, 32'd51, 32'hFFFF_FFFF, "cont_count0");
        wait_irq(t1);
        check("irq_period_1", 32'(t1 - t0), 32'd201);
        axi_read_rng(4'h8, 32'd49, 32'd51, 32'hFFFF_FFFF, "cont_count1");
        wait_irq(t2);
        check("irq_period_2", 32'(t2 - t1), 32'd201);
        repeat (210) @(posedge clk);
        @(negedge clk);
        check("irq_held", {31'd0, irq}, 32'd1);
        axi_read_rng(4'hC, 32'h9, 32'h9, 32'h9, "status_missed");
        axi_read_rng(4'h8, 32'd49, 32'd51, 32'hFFFF_FFFF, "cont_count2");
        axi_write(4'hC, 32'h8, 4'hF);
        axi_read_rng(4'hC, 32'h0, 32'h0, 32'h8, "missed_w1c");
        axi_write(4'h0, 32'h8, 4'hF);
        axi_read_rng(4'h8, 32'd49, 32'd51, 32'hFFFF_FFFF, "cont_count3");
        @(negedge clk);
        check("irq_off", {31'd0, irq}, 32'd0);

        // Abort during a long window
        fin_half = 3;
        axi_write(4'h4, 32'd5000, 4'hF);
        axi_write(4'h0, 32'h1, 4'hF);
        repeat (50) @(posedge clk);
        axi_read_rng(4'hC, 32'h2, 32'h2, 32'h3, "abort_busy");
        axi_write(4'h0, 32'h8, 4'hF);
        axi_read_rng(4'hC, 32'h0, 32'h0, 32'h3, "abort_idle");
        axi_read_rng(4'h8, 32'd49, 32'd51, 32'hFFFF_FFFF, "abort_count_kept");
        axi_write(4'h8, 32'hFFFF_FFFF, 4'hF);
        axi_read_rng(4'h8, 32'd49, 32'd51, 32'hFFFF_FFFF, "count_ro");

        // Byte strobe on GATE: 0x1388 with byte1 <- 0xAA
        axi_write(4'h4, 32'hDEAD_AAEF, 4'b0010);
        axi_read(4'h4, 32'h0000_AA88, "gate_wstrb");

        // B stall: response held, second write not accepted meanwhile
        bus.bready = 1'b0;
        aw_w_drive(4'h0, 32'h0, 4'hF);
        aw_w_accept();
        aw_w_drive(4'h4, 32'd100, 4'hF);
        stable = 0;
        acc    = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.bvalid) stable++;
            if (bus.awready) acc++;
        end
        check("bvalid_held", 32'(stable), 32'd10);
        check("aw_blocked", 32'(acc), 32'd0);
        @(posedge clk);
        #1;
        bus.bready = 1'b1;
        aw_w_accept();
        b_wait();
        axi_read(4'h4, 32'd100, "gate_after_stall");

        // R stall: RVALID and RDATA held while RREADY low
        bus.rready = 1'b0;
        ar_phase(4'h4, 32'd100, 32'd100, 32'hFFFF_FFFF, "r_stall_data");
        @(negedge clk);
        rd0    = bus.rdata;
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rvalid && bus.rdata == rd0) stable++;
        end
        check("rvalid_held", 32'(stable), 32'd10);
        @(posedge clk);
        #1;
        bus.rready = 1'b1;
        r_wait();

        repeat (5) @(posedge clk);
        check("queues_drained", 32'(rq.size() + bq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
